// File: rtl/div_32.sv
// rtl/div_32.sv - 32-bit signed restoring divider, one quotient bit per cycle
// Quotient truncates toward zero; remainder takes the dividend's sign.

module div_32 (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        ctrl_DIV,
  input  logic [31:0] operand_A,
  input  logic [31:0] operand_B,
  output logic [31:0] result,
  output logic [31:0] remainder,
  output logic        exception,
  output logic        data_resultRDY,
  output logic        busy
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_CAPT = 3'd1,
    S_ITER = 3'd2,
    S_FIX  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t      r_state;
  logic [31:0] r_op_a;
  logic [31:0] r_op_b;
  logic [31:0] r_dvd;
  logic [31:0] r_dvs;
  logic [32:0] r_rem;
  logic [5:0]  r_cnt;
  logic        r_sign_a;
  logic        r_sign_q;
  logic        r_ovf;
  logic [31:0] r_result;
  logic [31:0] r_remainder;
  logic        r_exception;
  logic        r_rdy;
  logic        r_busy;

  logic [31:0] w_abs_a;
  logic [31:0] w_abs_b;
  logic [33:0] w_shift;
  logic [33:0] w_diff;
  logic [31:0] w_q_fix;
  logic [31:0] w_r_fix;

  assign w_abs_a = r_op_a[31] ? (32'd0 - r_op_a) : r_op_a;
  assign w_abs_b = r_op_b[31] ? (32'd0 - r_op_b) : r_op_b;

  // The dividend register doubles as the quotient: its MSB shifts into the
  // remainder while the new quotient bit enters at the LSB.
  assign w_shift = {r_rem, r_dvd[31]};
  assign w_diff  = w_shift - {2'b00, r_dvs};

  assign w_q_fix = r_sign_q ? (32'd0 - r_dvd) : r_dvd;
  assign w_r_fix = r_sign_a ? (32'd0 - r_rem[31:0]) : r_rem[31:0];

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_op_a      <= 32'd0;
      r_op_b      <= 32'd0;
      r_dvd       <= 32'd0;
      r_dvs       <= 32'd0;
      r_rem       <= 33'd0;
      r_cnt       <= 6'd0;
      r_sign_a    <= 1'b0;
      r_sign_q    <= 1'b0;
      r_ovf       <= 1'b0;
      r_result    <= 32'd0;
      r_remainder <= 32'd0;
      r_exception <= 1'b0;
      r_rdy       <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_rdy <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE: begin
          if (ctrl_DIV) begin
            r_op_a <= operand_A;
            r_op_b <= operand_B;
            if (operand_B == 32'd0) begin
              // Divide-by-zero skips the datapath entirely.
              r_state     <= S_DONE;
              r_result    <= 32'd0;
              r_remainder <= 32'd0;
              r_exception <= 1'b1;
              r_rdy       <= 1'b1;
              r_busy      <= 1'b0;
            end else begin
              r_state <= S_CAPT;
              r_busy  <= 1'b1;
            end
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_CAPT: begin
          r_dvd    <= w_abs_a;
          r_dvs    <= w_abs_b;
          r_sign_a <= r_op_a[31];
          r_sign_q <= r_op_a[31] ^ r_op_b[31];
          r_rem    <= 33'd0;
          r_cnt    <= 6'd0;
          r_ovf    <= (r_op_a == 32'h8000_0000) && (r_op_b == 32'hFFFF_FFFF);
          r_state  <= S_ITER;
        end
        S_ITER: begin
          if (w_diff[33]) begin
            r_rem <= w_shift[32:0];
            r_dvd <= {r_dvd[30:0], 1'b0};
          end else begin
            r_rem <= w_diff[32:0];
            r_dvd <= {r_dvd[30:0], 1'b1};
          end
          r_cnt <= r_cnt + 6'd1;
          if (r_cnt == 6'd31) begin
            r_state <= S_FIX;
          end
        end
        S_FIX: begin
          r_result    <= w_q_fix;
          r_remainder <= w_r_fix;
          r_exception <= r_ovf;
          r_rdy       <= 1'b1;
          r_busy      <= 1'b0;
          r_state     <= S_DONE;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign result         = r_result;
  assign remainder      = r_remainder;
  assign exception      = r_exception;
  assign data_resultRDY = r_rdy;
  assign busy           = r_busy;

endmodule
